// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
// Shared definitions for one lane (processing element) of the SIMD matrix
// engine: data width, the data-word type, the DIMEN vector-length encoding
// and the helper that turns DIMEN into an element count.
// ---------------------------------------------------------------------------
package pe_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  // DIMEN encoding: vector length = 2 << DIMEN
  localparam logic [1:0] DIMEN_LEN2  = 2'b00;
  localparam logic [1:0] DIMEN_LEN4  = 2'b01;
  localparam logic [1:0] DIMEN_LEN8  = 2'b10;
  localparam logic [1:0] DIMEN_LEN16 = 2'b11;

  // Element count selected by DIMEN, clamped to the buffer depth so a lane
  // built with a shallow buffer never indexes past its last word.
  function automatic int dimen_to_len(input logic [1:0] dimen, input int n);
    int len;
    len = 2 << dimen;
    if (len > n) begin
      len = n;
    end
    return len;
  endfunction

endpackage : pe_pkg

// File: rtl/pe_vec_buf.sv
// ---------------------------------------------------------------------------
// pe_vec_buf
// N x DATA_W register file holding one operand vector of the lane.
// Synchronous write, combinational read, asynchronous clear.
//
// Ports:
//   clk_i    in   clock, writes on rising edge
//   rst_ni   in   asynchronous active-low clear of every word
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  word at raddr_i (reflects contents before a same-edge write)
// ---------------------------------------------------------------------------
module pe_vec_buf
  import pe_pkg::*;
#(
  parameter int N  = 16,
  parameter int AW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  word_t         wdata_i,
  input  logic [AW-1:0] raddr_i,
  output word_t         rdata_o
);

  word_t mem_q [N];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : pe_vec_buf

// File: rtl/processing_element.sv
// ---------------------------------------------------------------------------
// processing_element
// One lane of the SIMD matrix engine. Two local vectors (A = row, B = column)
// are loaded serially over DATAIN; the lane then computes their dot product
// with one multiply-accumulate per clock and raises MAC_DONE once the last
// element of the selected length has been accumulated.
//
// Ports:
//   CLK        in   system clock
//   RSTN       in   asynchronous active-low reset of all state and buffers
//   RST_ADD    in   synchronous clear of the write-address counter
//   RST_PC     in   synchronous clear of element pointer and MAC_DONE
//   RST_ACC    in   synchronous clear of the accumulator
//   DATAIN     in   buffer write data
//   WRITE_MAT  in   buffer write strobe
//   MAT_MUX    in   write select: 1 = A, 0 = B
//   MAC_CTRL   in   MAC enable, one step per cycle
//   DIMEN      in   vector length select (2 << DIMEN, clamped to N)
//   OUT_READY  in   output enable for DATAOUT
//   MAC_DONE   out  sticky completion flag
//   DATAOUT    out  accumulator when OUT_READY, else 0
// ---------------------------------------------------------------------------
module processing_element
  import pe_pkg::*;
#(
  parameter int N = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              RST_ADD,
  input  logic              RST_PC,
  input  logic              RST_ACC,
  input  logic [DATA_W-1:0] DATAIN,
  input  logic              WRITE_MAT,
  input  logic              MAT_MUX,
  input  logic              MAC_CTRL,
  input  logic [1:0]        DIMEN,
  input  logic              OUT_READY,
  output logic              MAC_DONE,
  output logic [DATA_W-1:0] DATAOUT
);

  localparam int AW = $clog2(N);
  typedef logic [AW-1:0] addr_t;

  addr_t waddr_q, waddr_d;
  addr_t pc_q,    pc_d;
  word_t acc_q,   acc_d;
  logic  done_q,  done_d;

  word_t a_rd, b_rd;
  logic  we_a, we_b;
  logic  mac_step;
  addr_t last_pc;

  // Unsigned multiply-accumulate: product keeps its low DATA_W bits and the
  // sum wraps modulo 2^DATA_W.
  function automatic word_t mac_wrap(input word_t acc, input word_t a, input word_t b);
    word_t prod;
    prod = a * b;
    return acc + prod;
  endfunction

  // ---- operand buffers -----------------------------------------------------
  assign we_a = WRITE_MAT &  MAT_MUX;
  assign we_b = WRITE_MAT & ~MAT_MUX;

  pe_vec_buf #(
    .N  (N),
    .AW (AW)
  ) u_buf_a (
    .clk_i   (CLK),
    .rst_ni  (RSTN),
    .we_i    (we_a),
    .waddr_i (waddr_q),
    .wdata_i (DATAIN),
    .raddr_i (pc_q),
    .rdata_o (a_rd)
  );

  pe_vec_buf #(
    .N  (N),
    .AW (AW)
  ) u_buf_b (
    .clk_i   (CLK),
    .rst_ni  (RSTN),
    .we_i    (we_b),
    .waddr_i (waddr_q),
    .wdata_i (DATAIN),
    .raddr_i (pc_q),
    .rdata_o (b_rd)
  );

  // ---- next-state logic ----------------------------------------------------
  assign last_pc  = addr_t'(dimen_to_len(DIMEN, N) - 1);
  assign mac_step = MAC_CTRL & ~done_q;

  // Write address: N is a power of two, so the natural AW-bit rollover gives
  // the N-1 -> 0 wrap. RST_ADD wins over the increment but not the write.
  always_comb begin
    waddr_d = waddr_q;
    if (WRITE_MAT) begin
      waddr_d = waddr_q + 1'b1;
    end
    if (RST_ADD) begin
      waddr_d = '0;
    end
  end

  // MAC sequencing: pc holds on the last element so MAC_DONE stays sticky
  // with the pointer parked; the clears override a same-cycle step.
  always_comb begin
    pc_d   = pc_q;
    acc_d  = acc_q;
    done_d = done_q;
    if (mac_step) begin
      acc_d = mac_wrap(acc_q, a_rd, b_rd);
      if (pc_q == last_pc) begin
        done_d = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
    if (RST_ACC) begin
      acc_d = '0;
    end
    if (RST_PC) begin
      pc_d   = '0;
      done_d = 1'b0;
    end
  end

  // ---- state registers -----------------------------------------------------
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      waddr_q <= '0;
      pc_q    <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      waddr_q <= waddr_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
    end
  end

  // ---- outputs -------------------------------------------------------------
  assign MAC_DONE = done_q;
  assign DATAOUT  = OUT_READY ? acc_q : '0;

endmodule : processing_element

// File: tb/tb_processing_element.sv
module tb_processing_element;

  localparam int N = 16;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        RST_ADD = 1'b0;
  logic        RST_PC = 1'b0;
  logic        RST_ACC = 1'b0;
  logic [31:0] DATAIN = '0;
  logic        WRITE_MAT = 1'b0;
  logic        MAT_MUX = 1'b0;
  logic        MAC_CTRL = 1'b0;
  logic [1:0]  DIMEN = 2'b00;
  logic        OUT_READY = 1'b0;
  logic        MAC_DONE;
  logic [31:0] DATAOUT;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  processing_element #(.N(N)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .RST_ADD   (RST_ADD),
    .RST_PC    (RST_PC),
    .RST_ACC   (RST_ACC),
    .DATAIN    (DATAIN),
    .WRITE_MAT (WRITE_MAT),
    .MAT_MUX   (MAT_MUX),
    .MAC_CTRL  (MAC_CTRL),
    .DIMEN     (DIMEN),
    .OUT_READY (OUT_READY),
    .MAC_DONE  (MAC_DONE),
    .DATAOUT   (DATAOUT)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural reference model ----------------
  logic [31:0] mA [N];
  logic [31:0] mB [N];
  int          m_waddr;
  int          m_steps;    // elements accumulated so far in this sequence
  logic [31:0] m_acc;
  bit          m_done;

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < N; i++) begin
        mA[i] = '0;
        mB[i] = '0;
      end
      m_waddr = 0;
      m_steps = 0;
      m_acc   = '0;
      m_done  = 1'b0;
    end else begin
      int len;
      logic [31:0] prod;
      len = 2 << DIMEN;
      if (len > N) len = N;
      // MAC reads the buffers as they were before this edge's write
      if (MAC_CTRL && !m_done) begin
        prod  = mA[m_steps] * mB[m_steps];
        m_acc = m_acc + prod;
        if (m_steps + 1 == len) m_done = 1'b1;
        else m_steps = m_steps + 1;
      end
      if (RST_ACC) m_acc = '0;
      if (RST_PC) begin
        m_steps = 0;
        m_done  = 1'b0;
      end
      if (WRITE_MAT) begin
        if (MAT_MUX) mA[m_waddr] = DATAIN;
        else         mB[m_waddr] = DATAIN;
        m_waddr = (m_waddr + 1) % N;
      end
      if (RST_ADD) m_waddr = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("model_mac_done", {31'd0, MAC_DONE}, {31'd0, m_done});
      check("model_dataout", DATAOUT, OUT_READY ? m_acc : 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [31:0] d, input logic rst_add);
    WRITE_MAT = 1'b1;
    MAT_MUX   = sel;
    DATAIN    = d;
    RST_ADD   = rst_add;
    tick();
    WRITE_MAT = 1'b0;
    RST_ADD   = 1'b0;
  endtask

  task automatic mac(input int n);
    MAC_CTRL = 1'b1;
    repeat (n) tick();
    MAC_CTRL = 1'b0;
  endtask

  task automatic clr_all();
    RST_PC = 1'b1; RST_ACC = 1'b1; RST_ADD = 1'b1;
    tick();
    RST_PC = 1'b0; RST_ACC = 1'b0; RST_ADD = 1'b0;
  endtask

  initial begin
    // reset
    repeat (3) @(posedge CLK);
    #1;
    check("reset_done", {31'd0, MAC_DONE}, 32'd0);
    check("reset_dataout", DATAOUT, 32'd0);
    RSTN = 1'b1;
    cmp_en = 1'b1;
    tick();

    // 2-element dot product
    wr(1'b1, 32'd45, 1'b0);
    wr(1'b1, 32'd34, 1'b1);
    wr(1'b0, 32'd65, 1'b0);
    wr(1'b0, 32'd79, 1'b0);
    DIMEN = 2'b00;
    MAC_CTRL = 1'b1;
    tick();
    check("dot2_done_after1", {31'd0, MAC_DONE}, 32'd0);
    tick();
    check("dot2_done_after2", {31'd0, MAC_DONE}, 32'd1);
    tick();
    MAC_CTRL = 1'b0;
    check("dot2_out_disabled", DATAOUT, 32'd0);
    OUT_READY = 1'b1;
    #1;
    check("dot2_result", DATAOUT, 32'd5611);

    // length 16
    clr_all();
    for (int i = 0; i < 16; i++) wr(1'b1, 32'(i + 1), 1'b0);
    for (int i = 0; i < 16; i++) wr(1'b0, 32'd2, 1'b0);
    DIMEN = 2'b11;
    mac(15);
    check("len16_done_after15", {31'd0, MAC_DONE}, 32'd0);
    mac(1);
    check("len16_done_after16", {31'd0, MAC_DONE}, 32'd1);
    check("len16_result", DATAOUT, 32'd272);
    mac(4);
    check("len16_hold", DATAOUT, 32'd272);

    // overflow wrap
    clr_all();
    wr(1'b1, 32'h0001_0000, 1'b0);
    wr(1'b1, 32'd3, 1'b1);
    wr(1'b0, 32'h0001_0000, 1'b0);
    wr(1'b0, 32'd3, 1'b1);
    DIMEN = 2'b00;
    mac(2);
    check("overflow_result", DATAOUT, 32'd9);

    // pause / resume, length 4
    clr_all();
    for (int i = 0; i < 4; i++) wr(1'b1, 32'(i + 1), i == 3);
    for (int i = 0; i < 4; i++) wr(1'b0, 32'(i + 5), i == 3);
    DIMEN = 2'b01;
    mac(2);
    repeat (3) tick();
    check("pause_done_mid", {31'd0, MAC_DONE}, 32'd0);
    mac(1);
    check("pause_done_after3", {31'd0, MAC_DONE}, 32'd0);
    mac(1);
    check("pause_done_after4", {31'd0, MAC_DONE}, 32'd1);
    check("pause_result", DATAOUT, 32'd70);

    // reset controls
    RST_PC = 1'b1; RST_ACC = 1'b1;
    tick();
    RST_PC = 1'b0; RST_ACC = 1'b0;
    check("rstctl_done", {31'd0, MAC_DONE}, 32'd0);
    check("rstctl_dataout", DATAOUT, 32'd0);
    mac(4);
    check("rerun_result", DATAOUT, 32'd70);
    RST_PC = 1'b1; RST_ACC = 1'b1;
    tick();
    RST_PC = 1'b0; RST_ACC = 1'b0;
    MAC_CTRL = 1'b1;
    tick();
    tick();
    RSTN = 1'b0;
    #1;
    check("rstn_mid_dataout", DATAOUT, 32'd0);
    check("rstn_mid_done", {31'd0, MAC_DONE}, 32'd0);
    MAC_CTRL = 1'b0;
    tick();
    RSTN = 1'b1;
    tick();

    // write-address wrap: 17 writes to B
    for (int i = 0; i < 17; i++) wr(1'b0, 32'(100 + i), 1'b0);
    RST_ADD = 1'b1;
    tick();
    RST_ADD = 1'b0;
    wr(1'b1, 32'd1, 1'b0);
    wr(1'b1, 32'd0, 1'b0);
    DIMEN = 2'b00;
    mac(2);
    check("waddr_wrap_b0", DATAOUT, 32'd116);

    // randomized traffic checked by the model
    clr_all();
    for (int c = 0; c < 600; c++) begin
      WRITE_MAT = ($urandom_range(0, 2) == 0);
      MAT_MUX   = $urandom_range(0, 1) == 1;
      DATAIN    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      MAC_CTRL  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      RST_ADD   = ($urandom_range(0, 15) == 0);
      RST_ACC   = ($urandom_range(0, 24) == 0);
      RST_PC    = 1'b0;
      // DIMEN only changes together with a pointer clear
      if ($urandom_range(0, 19) == 0) begin
        RST_PC = 1'b1;
        DIMEN  = 2'($urandom_range(0, 3));
      end
      tick();
    end
    WRITE_MAT = 1'b0; MAC_CTRL = 1'b0; RST_ADD = 1'b0; RST_ACC = 1'b0; RST_PC = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_processing_element
